alu_mul_sequencer: RTL

//  Multi-cycle shift-add multiplier controller that reuses the single-cycle ALU instead of a hardware multiplier.

---
 rtl/alu_mul_sequencer_if.sv | 30 +++
 rtl/alu_mul_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Bus between the shift-add multiply sequencer and its neighbours: the
// request/result handshake on one side and the borrowed ALU on the other.
interface alu_mul_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int MBITS = 16
);
   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [MBITS-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [4:0]       alu_shamt;
   logic [3:0]       alu_operation;
   logic [WIDTH-1:0] alu_result;

   // requester side plus the ALU that answers combinationally
   modport master (
      output start, multiplicand, multiplier, alu_result,
      input  busy, done, product, alu_a, alu_b, alu_shamt, alu_operation
   );

   // the sequencer itself
   modport slave (
      input  start, multiplicand, multiplier, alu_result,
      output busy, done, product, alu_a, alu_b, alu_shamt, alu_operation
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller. Borrows the single-cycle ALU: one ADD or
// SLL per cycle, with a TEST cycle between steps. Loop exits as soon as the
// remaining multiplier bits are all zero.
module alu_mul_sequencer #(
   parameter int WIDTH = 32,
   parameter int MBITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_mul_sequencer_if.slave   bus
);

   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_IDLE = 4'b1001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TEST,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [MBITS-1:0] mplier;
   logic [WIDTH-1:0] product_q;

   // state register and datapath registers; ALU result is captured on the
   // same edge that ends the ADD/SHIFT cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         product_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  acc    <= '0;
                  mcand  <= bus.multiplicand;
                  mplier <= bus.multiplier;
               end
            end
            S_TEST: begin
               // product lands on the edge entering DONE
               if (mplier == '0)
                  product_q <= acc;
            end
            S_ADD: begin
               acc <= bus.alu_result;
            end
            S_SHIFT: begin
               mcand  <= bus.alu_result;
               mplier <= mplier >> 1;
            end
            default: ;
         endcase
      end
   end

   // next-state and Moore outputs; ALU controls never look at start
   always_comb begin
      state_nxt         = state;
      bus.busy          = 1'b0;
      bus.done          = 1'b0;
      bus.alu_a         = '0;
      bus.alu_b         = '0;
      bus.alu_shamt     = 5'd0;
      bus.alu_operation = OP_IDLE;
      case (state)
         S_IDLE: begin
            if (bus.start)
               state_nxt = S_TEST;
         end
         S_TEST: begin
            bus.busy = 1'b1;
            if (mplier == '0)
               state_nxt = S_DONE;
            else if (mplier[0])
               state_nxt = S_ADD;
            else
               state_nxt = S_SHIFT;
         end
         S_ADD: begin
            bus.busy          = 1'b1;
            bus.alu_a         = acc;
            bus.alu_b         = mcand;
            bus.alu_operation = OP_ADD;
            state_nxt         = S_SHIFT;
         end
         S_SHIFT: begin
            bus.busy          = 1'b1;
            bus.alu_b         = mcand;
            bus.alu_shamt     = 5'd1;
            bus.alu_operation = OP_SLL;
            state_nxt         = S_TEST;
         end
         S_DONE: begin
            bus.done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.product = product_q;

endmodule
